// File: rtl/led_seq_pkg.sv
// ---------------------------------------------------------------------------
// led_seq_pkg
// Shared types for the LED bar sequencer: the pattern-mode encoding as seen
// on the mode input, the sequencer FSM states, and small mode helpers.
// ---------------------------------------------------------------------------
package led_seq_pkg;

    // Pattern select; MODE_RSVD is treated exactly like MODE_FILL.
    typedef enum logic [1:0] {
        MODE_FILL   = 2'd0,
        MODE_DRAIN  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_UP = 2'd1,
        RUN_DN = 2'd2,
        DONE   = 2'd3
    } state_e;

    // A drain run starts full and counts down.
    function automatic logic is_drain(input mode_e m);
        return (m == MODE_DRAIN);
    endfunction

    // A bounce run reverses direction at each end instead of finishing.
    function automatic logic is_bounce(input mode_e m);
        return (m == MODE_BOUNCE);
    endfunction

endpackage

// File: rtl/led_step_div.sv
// ---------------------------------------------------------------------------
// led_step_div
// Step divider: counts enabled clk cycles and raises tick on the cycle in
// which the count sits at DIV-1, wrapping back to 0 at that edge.
//
// Ports:
//   clk   in   clock, rising edge
//   rst_n in   asynchronous active-low reset (count -> 0)
//   clr   in   synchronous clear, overrides en; suppresses tick
//   en    in   count enable
//   tick  out  step strobe, valid in the cycle before the edge it acts on
// ---------------------------------------------------------------------------
module led_step_div #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // DIV=1 still needs a 1-bit counter; it simply never leaves 0.
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;

    // Divider count register: clear has priority, wraps at LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            if (cnt_r == LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = en & ~clr & (cnt_r == LAST);

endmodule

// File: rtl/led_bar_seq.sv
// ---------------------------------------------------------------------------
// led_bar_seq
// LED bar sequencer: drives a WIDTH-LED thermometer bar that fills, drains or
// bounces one LED per DIV clk cycles after a button start.
//
// Parameters:
//   WIDTH  number of LEDs (2..32)
//   DIV    clk cycles per LED step (1..65535)
//
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   button  in   start/restart (level, sampled each edge, wins over pause)
//   mode    in   [1:0] pattern: 0 fill, 1 drain, 2 bounce, 3 as fill
//   pause   in   freezes divider and level while high
//   led     out  [WIDTH-1:0] thermometer, bit i set iff i < level
//   busy    out  high in RUN_UP / RUN_DN
//   done    out  high in DONE
//
// Build option:
//   LED_BAR_SEQ_AUTOSTART_EN  when defined, reset lands in RUN_UP with fill
//                             latched, so a fill runs without a button press.
//
// All outputs are pure decodes of the state and level registers.
// ---------------------------------------------------------------------------
module led_bar_seq
    import led_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             button,
    input  logic [1:0]       mode,
    input  logic             pause,
    output logic [WIDTH-1:0] led,
    output logic             busy,
    output logic             done
);

    localparam int            LW      = $clog2(WIDTH + 1);
    localparam logic [LW-1:0] LVL_MAX = LW'(WIDTH);

`ifdef LED_BAR_SEQ_AUTOSTART_EN
    localparam state_e RST_STATE = RUN_UP;
`else
    localparam state_e RST_STATE = IDLE;
`endif

    state_e        state_r;
    state_e        state_s;
    mode_e         mode_r;
    mode_e         mode_s;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_s;
    logic          div_en_s;
    logic          tick_s;

    // The divider only runs while a run is active and not paused; a button
    // press clears it so the new run starts a full step period from now.
    assign div_en_s = ((state_r == RUN_UP) || (state_r == RUN_DN)) && !pause;

    led_step_div #(
        .DIV (DIV)
    ) u_step_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (button),
        .en    (div_en_s),
        .tick  (tick_s)
    );

    // State, level and latched-mode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RST_STATE;
            mode_r  <= MODE_FILL;
            level_r <= '0;
        end else begin
            state_r <= state_s;
            mode_r  <= mode_s;
            level_r <= level_s;
        end
    end

    // Next-state logic: button restarts from any state; otherwise each tick
    // moves the level one step and turns around or finishes at the ends.
    always_comb begin
        state_s = state_r;
        mode_s  = mode_r;
        level_s = level_r;
        if (button) begin
            mode_s = mode_e'(mode);
            if (is_drain(mode_e'(mode))) begin
                level_s = LVL_MAX;
                state_s = RUN_DN;
            end else begin
                level_s = '0;
                state_s = RUN_UP;
            end
        end else begin
            case (state_r)
                RUN_UP: begin
                    if (tick_s) begin
                        // Saturate at WIDTH; reaching it ends the upward leg.
                        if (level_r < LVL_MAX) begin
                            level_s = level_r + LW'(1);
                        end else begin
                            level_s = level_r;
                        end
                        if (level_r >= (LVL_MAX - LW'(1))) begin
                            state_s = is_bounce(mode_r) ? RUN_DN : DONE;
                        end else begin
                            state_s = RUN_UP;
                        end
                    end else begin
                        level_s = level_r;
                        state_s = state_r;
                    end
                end
                RUN_DN: begin
                    if (tick_s) begin
                        // Saturate at 0; reaching it ends the downward leg.
                        if (level_r > LW'(0)) begin
                            level_s = level_r - LW'(1);
                        end else begin
                            level_s = level_r;
                        end
                        if (level_r <= LW'(1)) begin
                            state_s = is_bounce(mode_r) ? RUN_UP : DONE;
                        end else begin
                            state_s = RUN_DN;
                        end
                    end else begin
                        level_s = level_r;
                        state_s = state_r;
                    end
                end
                IDLE: begin
                    state_s = IDLE;
                end
                DONE: begin
                    state_s = DONE;
                end
                default: begin
                    state_s = IDLE;
                    level_s = '0;
                end
            endcase
        end
    end

    // Output decode: thermometer bar from level, status flags from state.
    always_comb begin
        led = '0;
        for (int i = 0; i < WIDTH; i++) begin
            led[i] = (level_r > LW'(i));
        end
        busy = (state_r == RUN_UP) || (state_r == RUN_DN);
        done = (state_r == DONE);
    end

endmodule

// File: tb/tb_led_bar_seq.sv
// ---------------------------------------------------------------------------
// tb_led_bar_seq
// Self-checking bench for led_bar_seq. Three instances share clk/rst_n:
//   a: WIDTH=16 DIV=1, b: WIDTH=16 DIV=3, c: WIDTH=4 DIV=1.
// Each applied cycle pushes its expected outputs onto a scoreboard queue,
// which is popped and compared 1 time unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_led_bar_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        btn_a = 1'b0, btn_b = 1'b0, btn_c = 1'b0;
    logic [1:0]  mode_a = 2'd0, mode_b = 2'd0, mode_c = 2'd0;
    logic        pause_a = 1'b0, pause_b = 1'b0, pause_c = 1'b0;
    logic [15:0] led_a, led_b;
    logic [3:0]  led_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        button;
        logic [1:0]  mode;
        logic        pause;
        logic [15:0] led;
        logic        busy;
        logic        done;
    } vec_t;

    typedef struct {
        int          inst;
        string       tag;
        logic [15:0] led;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t sb[$];
    vec_t fill_tab[19];

    always #5 clk = ~clk;

    led_bar_seq #(.WIDTH(16), .DIV(1)) u_a (
        .clk(clk), .rst_n(rst_n), .button(btn_a), .mode(mode_a),
        .pause(pause_a), .led(led_a), .busy(busy_a), .done(done_a));

    led_bar_seq #(.WIDTH(16), .DIV(3)) u_b (
        .clk(clk), .rst_n(rst_n), .button(btn_b), .mode(mode_b),
        .pause(pause_b), .led(led_b), .busy(busy_b), .done(done_b));

    led_bar_seq #(.WIDTH(4), .DIV(1)) u_c (
        .clk(clk), .rst_n(rst_n), .button(btn_c), .mode(mode_c),
        .pause(pause_c), .led(led_c), .busy(busy_c), .done(done_c));

    function automatic logic [15:0] therm(input int lvl);
        logic [31:0] t;
        t = (32'd1 << lvl) - 32'd1;
        return t[15:0];
    endfunction

    function automatic void check(input string name, input logic [15:0] act,
                                  input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Compare the oldest scoreboard entry against the selected instance now.
    task automatic pop_check();
        exp_t        e;
        logic [15:0] al;
        logic        ab, ad;
        e = sb.pop_front();
        case (e.inst)
            0:       begin al = led_a;           ab = busy_a; ad = done_a; end
            1:       begin al = led_b;           ab = busy_b; ad = done_b; end
            default: begin al = {12'd0, led_c};  ab = busy_c; ad = done_c; end
        endcase
        check({e.tag, ".led"},  al, e.led);
        check({e.tag, ".busy"}, {15'd0, ab}, {15'd0, e.busy});
        check({e.tag, ".done"}, {15'd0, ad}, {15'd0, e.done});
    endtask

    // Drive one cycle of inputs, record expectation, clock, then compare.
    task automatic apply(input int inst, input logic b, input logic [1:0] m,
                         input logic p, input logic [15:0] el,
                         input logic eb, input logic ed, input string tag);
        exp_t e;
        case (inst)
            0:       begin btn_a = b; mode_a = m; pause_a = p; end
            1:       begin btn_b = b; mode_b = m; pause_b = p; end
            default: begin btn_c = b; mode_c = m; pause_c = p; end
        endcase
        e.inst = inst; e.tag = tag; e.led = el; e.busy = eb; e.done = ed;
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        // Fill table for instance a: start edge, 16 steps, then hold.
        fill_tab[0] = '{1'b1, 2'd0, 1'b0, 16'h0000, 1'b1, 1'b0};
        for (int k = 1; k <= 16; k++) begin
            fill_tab[k] = '{1'b0, 2'd0, 1'b0, therm(k), (k < 16), (k == 16)};
        end
        for (int k = 17; k < 19; k++) begin
            fill_tab[k] = '{1'b0, 2'd0, 1'b0, 16'hFFFF, 1'b0, 1'b1};
        end

        // Reset state, observed with no clock edge needed.
        #12;
        check("rst.led_a", led_a, 16'h0000);
        check("rst.led_b", led_b, 16'h0000);
        check("rst.done_a", {15'd0, done_a}, 16'd0);
`ifndef LED_BAR_SEQ_AUTOSTART_EN
        check("rst.busy_a", {15'd0, busy_a}, 16'd0);
        check("rst.busy_c", {15'd0, busy_c}, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

`ifdef LED_BAR_SEQ_AUTOSTART_EN
        // Autostart: fill runs from reset release without the button.
        for (int k = 1; k <= 16; k++) begin
            apply(0, 1'b0, 2'd0, 1'b0, therm(k), (k < 16), (k == 16),
                  $sformatf("auto[%0d]", k));
        end
`else
        // Idle after reset: no button, nothing moves.
        apply(0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, "idle0");
        apply(0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, "idle1");
`endif

        // Fill, DIV=1: one LED per edge, DONE on the 16th edge, then hold.
        for (int k = 0; k < 19; k++) begin
            apply(0, fill_tab[k].button, fill_tab[k].mode, fill_tab[k].pause,
                  fill_tab[k].led, fill_tab[k].busy, fill_tab[k].done,
                  $sformatf("fill[%0d]", k));
        end

        // Pause at level 7 for 5 cycles, then resume with 8.
        apply(0, 1'b1, 2'd0, 1'b0, 16'h0000, 1'b1, 1'b0, "pz.start");
        for (int k = 1; k <= 7; k++) begin
            apply(0, 1'b0, 2'd0, 1'b0, therm(k), 1'b1, 1'b0, $sformatf("pz.run%0d", k));
        end
        for (int k = 0; k < 5; k++) begin
            apply(0, 1'b0, 2'd0, 1'b1, therm(7), 1'b1, 1'b0, $sformatf("pz.hold%0d", k));
        end
        apply(0, 1'b0, 2'd0, 1'b0, therm(8), 1'b1, 1'b0, "pz.resume");
        // Button and pause together: button wins and restarts.
        apply(0, 1'b1, 2'd0, 1'b1, 16'h0000, 1'b1, 1'b0, "bp.restart");
        apply(0, 1'b0, 2'd0, 1'b0, therm(1), 1'b1, 1'b0, "bp.step");

        // Restart at level 10 into drain, then asynchronous reset mid-run.
        for (int k = 2; k <= 10; k++) begin
            apply(0, 1'b0, 2'd0, 1'b0, therm(k), 1'b1, 1'b0, $sformatf("rs.run%0d", k));
        end
        apply(0, 1'b1, 2'd1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "rs.drain");
        apply(0, 1'b0, 2'd1, 1'b0, 16'h7FFF, 1'b1, 1'b0, "rs.step");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.led", led_a, 16'h0000);
        check("arst.busy", {15'd0, busy_a}, 16'd0);
        check("arst.done", {15'd0, done_a}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
`ifndef LED_BAR_SEQ_AUTOSTART_EN
        apply(0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, "arst.idle");
`endif

        // Drain, DIV=3: step every third edge, DONE 48 edges after start.
        apply(1, 1'b1, 2'd1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "dr.start");
        for (int k = 1; k <= 50; k++) begin
            int lvl;
            lvl = (k >= 48) ? 0 : 16 - (k / 3);
            apply(1, 1'b0, 2'd1, 1'b0, therm(lvl), (k < 48), (k >= 48),
                  $sformatf("dr[%0d]", k));
        end

        // Bounce, WIDTH=4: triangle 0..4..0, never DONE.
        apply(2, 1'b1, 2'd2, 1'b0, 16'h0000, 1'b1, 1'b0, "bn.start");
        for (int k = 1; k <= 20; k++) begin
            int p;
            p = k % 8;
            apply(2, 1'b0, 2'd2, 1'b0, therm((p <= 4) ? p : 8 - p), 1'b1, 1'b0,
                  $sformatf("bn[%0d]", k));
        end

        // Reserved mode behaves as fill.
        apply(2, 1'b1, 2'd3, 1'b0, 16'h0000, 1'b1, 1'b0, "rv.start");
        for (int k = 1; k <= 5; k++) begin
            apply(2, 1'b0, 2'd3, 1'b0, therm((k > 4) ? 4 : k), (k < 4), (k >= 4),
                  $sformatf("rv[%0d]", k));
        end

        // Drain on WIDTH=4 ends at 0 and holds there.
        apply(2, 1'b1, 2'd1, 1'b0, 16'h000F, 1'b1, 1'b0, "d4.start");
        for (int k = 1; k <= 5; k++) begin
            apply(2, 1'b0, 2'd1, 1'b0, therm((k > 4) ? 0 : 4 - k), (k < 4), (k >= 4),
                  $sformatf("d4[%0d]", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
